// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared types and constants for the core hazard control slice
package core_ctrl_pkg;

   // Register-file index width (x0..x31)
   localparam int REG_W = 5;

   // Operand forwarding mux selects for the E stage
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Hazard scheduler states
   typedef enum logic {
      RUN      = 1'b0,
      MDU_WAIT = 1'b1
   } sched_state_t;

endpackage

// File: rtl/hazard_sched_unit_if.sv
// rtl/hazard_sched_unit_if.sv - start/done handshake between hazard scheduler and MDU
interface hazard_sched_unit_if;

   logic MduStart;
   logic MduDone;

   // master: the hazard scheduler launching MDU operations
   modport master (output MduStart, input MduDone);
   // slave: the multi-cycle MDU
   modport slave  (input MduStart, output MduDone);

endinterface

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - combinational E-stage operand forwarding compare for both operands
module hazard_fwd_unit
   import core_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] Rs1E,
   input  logic [REG_W-1:0] Rs2E,
   input  logic [REG_W-1:0] RdM,
   input  logic [REG_W-1:0] RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE
);

   // M wins over W because it holds the younger result; x0 is never forwarded
   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs);
      logic [1:0] sel;
      sel = FWD_RF;
      if (RegWriteM && (RdM != '0) && (RdM == rs))
         sel = FWD_MEM;
      else if (RegWriteW && (RdW != '0) && (RdW == rs))
         sel = FWD_WB;
      return sel;
   endfunction

   // Same compare applied to each E-stage source operand
   always_comb begin
      ForwardAE = fwd_sel(Rs1E);
      ForwardBE = fwd_sel(Rs2E);
   end

endmodule

// File: rtl/hazard_sched_unit.sv
// rtl/hazard_sched_unit.sv - pipeline stall/flush/forward control with MDU sequencing and perf counters
module hazard_sched_unit
   import core_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MDU_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_W-1:0]  Rs1D,
   input  logic [REG_W-1:0]  Rs2D,
   input  logic [REG_W-1:0]  Rs1E,
   input  logic [REG_W-1:0]  Rs2E,
   input  logic [REG_W-1:0]  RdE,
   input  logic [REG_W-1:0]  RdM,
   input  logic [REG_W-1:0]  RdW,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic              LoadE,
   input  logic              PCSrcE,
   input  logic              MduOpE,
   hazard_sched_unit_if.master mdu,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushM,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              mdu_err,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int              WD_W    = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MDU_TIMEOUT - 1);

   sched_state_t    state;
   sched_state_t    next_state;
   logic [WD_W-1:0] wd_cnt;
   logic            load_use;
   logic            wd_expired;
   logic            mdu_start;
   logic [1:0]      fwd_a;
   logic [1:0]      fwd_b;

   hazard_fwd_unit u_fwd (
      .Rs1E      (Rs1E),
      .Rs2E      (Rs2E),
      .RdM       (RdM),
      .RdW       (RdW),
      .RegWriteM (RegWriteM),
      .RegWriteW (RegWriteW),
      .ForwardAE (fwd_a),
      .ForwardBE (fwd_b)
   );

   // Forward selects are held at the register file while in reset
   always_comb begin
      ForwardAE = rst_n ? fwd_a : FWD_RF;
      ForwardBE = rst_n ? fwd_b : FWD_RF;
   end

   // Hazard detection terms
   always_comb begin
      load_use   = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
      wd_expired = (wd_cnt == WD_LAST);
   end

   // Priority decode of pipeline controls and next state; all quiet during reset
   always_comb begin
      StallF     = 1'b0;
      StallD     = 1'b0;
      StallE     = 1'b0;
      FlushD     = 1'b0;
      FlushE     = 1'b0;
      FlushM     = 1'b0;
      mdu_start  = 1'b0;
      next_state = state;
      if (rst_n) begin
         case (state)
            RUN: begin
               if (MduOpE) begin
                  // Freeze F/D/E while the MDU works, bubble into M
                  mdu_start  = 1'b1;
                  StallF     = 1'b1;
                  StallD     = 1'b1;
                  StallE     = 1'b1;
                  FlushM     = 1'b1;
                  next_state = MDU_WAIT;
               end else if (PCSrcE) begin
                  // D holds a wrong-path instruction, so any load-use on it is moot
                  FlushD = 1'b1;
                  FlushE = 1'b1;
               end else if (load_use) begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  FlushE = 1'b1;
               end
            end
            MDU_WAIT: begin
               if (mdu.MduDone || wd_expired) begin
                  // Release: the MDU instruction advances to M, no relaunch
                  next_state = RUN;
               end else begin
                  StallF = 1'b1;
                  StallD = 1'b1;
                  StallE = 1'b1;
                  FlushM = 1'b1;
               end
            end
            default: next_state = RUN;
         endcase
      end
   end

   assign mdu.MduStart = mdu_start;

   // State, watchdog, sticky error and saturating performance counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         wd_cnt    <= '0;
         mdu_err   <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= next_state;
         if ((state == MDU_WAIT) && (next_state == MDU_WAIT))
            wd_cnt <= wd_cnt + WD_W'(1);
         else
            wd_cnt <= '0;
         if ((state == MDU_WAIT) && !mdu.MduDone && wd_expired)
            mdu_err <= 1'b1;
         if (StallF && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         // FlushD is raised only by an accepted branch/jump
         if (FlushD && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/hazard_sched_unit.md
Name: hazard_sched_unit

Overview:
- Central hazard controller for the 5-stage pipelined RV32 core.
- Drives the stall and flush controls of the F, D, E and M pipeline registers (IF/DEC, DEC/EX, EX/MEM) and the E-stage operand forwarding muxes.
- Sequences multi-cycle multiply/divide (MDU) operations through a start/done handshake with a watchdog.
- Keeps saturating stall and flush performance counters.

Parameters:
- CNT_W, 32, width of the stall_cnt and flush_cnt performance counters.
- MDU_TIMEOUT, 64, maximum number of cycles in MDU_WAIT before a forced exit (must be >= 2).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous, active-low.
- Rs1D, Rs2D  in  5  source registers of the instruction in D.
- Rs1E, Rs2E, RdE  in  5  source and destination registers of the instruction in E.
- RdM, RdW  in  5  destination registers in M and W.
- RegWriteM, RegWriteW  in  1  the instruction in M / W writes the register file.
- LoadE  in  1  the instruction in E is a load.
- PCSrcE  in  1  taken branch or jump resolved in E.
- MduOpE  in  1  the instruction in E is a multi-cycle MDU operation.
- MduDone  in  1  MDU result valid; single-cycle pulse.
- StallF, StallD, StallE  out  1  hold the PC, IF/DEC and DEC/EX registers.
- FlushD, FlushE, FlushM  out  1  clear IF/DEC, DEC/EX and EX/MEM (inject a bubble).
- ForwardAE, ForwardBE  out  2  operand select: 00 = register file, 01 = W result, 10 = M ALU result.
- MduStart  out  1  launch the MDU.
- mdu_err  out  1  sticky watchdog error.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

Behaviour:
- FSM states: RUN, MDU_WAIT. Reset state is RUN.
- Reset values: stall_cnt = 0, flush_cnt = 0, mdu_err = 0, watchdog counter = 0.
- While rst_n is low, every stall, flush, start and forward output is forced to 0.

Forwarding (combinational, valid in every state):
- ForwardAE = 10 if RegWriteM && RdM != 0 && RdM == Rs1E.
- Otherwise ForwardAE = 01 if RegWriteW && RdW != 0 && RdW == Rs1E.
- Otherwise ForwardAE = 00.
- The M match has priority over the W match.
- ForwardBE is identical, using Rs2E.

RUN state, in priority order (the first matching rule sets the outputs; unlisted outputs are 0):
- MduOpE:
  - MduStart = 1, StallF = 1, StallD = 1, StallE = 1, FlushM = 1.
  - Next state is MDU_WAIT.
  - A simultaneous PCSrcE is ignored; decode guarantees exclusivity.
- PCSrcE:
  - FlushD = 1, FlushE = 1.
  - flush_cnt increments.
  - A concurrent load-use condition is discarded, because D holds a wrong-path instruction.
- Load-use, i.e. LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D):
  - StallF = 1, StallD = 1, FlushE = 1.
  - Lasts exactly 1 cycle, because the load advances to M in the next cycle.

MDU_WAIT state:
- Each cycle without MduDone: StallF = StallD = StallE = 1, FlushM = 1, MduStart = 0; the watchdog counter increments.
- MduDone high: all stalls and flushes = 0, so the MDU instruction advances to M. Next state is RUN and the watchdog is cleared.
  - MduOpE is still high in this cycle; it must not relaunch the MDU.
- Watchdog reaches MDU_TIMEOUT - 1 without MduDone:
  - Outputs are the same as for MduDone.
  - mdu_err is set and held until reset.
- MduDone asserted in RUN is ignored.
- Total stall latency of an MDU operation = number of MDU_WAIT cycles before MduDone, plus the launch cycle.

Counters:
- stall_cnt increments in every cycle with StallF = 1.
- flush_cnt increments per accepted PCSrcE.
- Both saturate at 2^CNT_W - 1 and do not wrap.

Reset during MDU_WAIT:
- Immediate return to RUN, counters cleared.
- No MduStart is re-issued.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - FSM state enum.
  - FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - Register-index width 5.
- Sub-module hazard_fwd_unit: purely combinational forwarding compare, instantiated once and reused for both operands.
- FSM, priority logic and counters remain in the top module.

Test Plan:
1. Forwarding:
   - Stimulus: RegWriteM = 1, RdM = 5, RegWriteW = 1, RdW = 5, Rs1E = 5.
   - Required: ForwardAE = 10.
   - Then RdM = 0: ForwardAE = 01.
   - Then Rs1E = 0: ForwardAE = 00.
2. Load-use:
   - Stimulus: LoadE = 1, RdE = 7, Rs2D = 7 for one cycle.
   - Required: StallF = StallD = FlushE = 1 for exactly that cycle; stall_cnt increments by 1.
   - Same stimulus with RdE = 0: no stall.
3. Branch over load-use:
   - Stimulus: PCSrcE = 1 together with the load-use condition.
   - Required: FlushD = FlushE = 1, StallF = 0, flush_cnt increments by 1.
4. MDU:
   - Stimulus: MduOpE = 1; MduDone pulses 4 cycles later.
   - Required: MduStart is high in the launch cycle only.
   - StallE = FlushM = 1 for 4 cycles, 0 in the MduDone cycle.
   - State returns to RUN and stall_cnt increments by 4.
5. Watchdog:
   - Stimulus: MDU_TIMEOUT = 8, MduDone never asserted.
   - Required: forced exit after 8 MDU_WAIT cycles; mdu_err = 1 and stays 1.
   - Next MduOpE launches normally.
6. Reset and saturation:
   - Stimulus: rst_n low during MDU_WAIT.
   - Required: all outputs 0, state RUN, counters 0.
   - With CNT_W = 3 and 10 consecutive stall cycles: stall_cnt holds at 7.
